// File: rtl/fir_audio_pkg.sv
// ---------------------------------------------------------------------------
// fir_audio_pkg
// Shared constants and types for the 48 kHz audio FIR path.
//   SAMPLE_W  : ADC / FIR sample word width (two's complement)
//   DIV_RATIO : clk_audio_12M288 cycles per 48 kHz sample period
//   sample_t  : one sample word
// ---------------------------------------------------------------------------
package fir_audio_pkg;

   localparam int SAMPLE_W  = 16;
   localparam int DIV_RATIO = 256;

   typedef logic [SAMPLE_W-1:0] sample_t;

endpackage : fir_audio_pkg

// File: rtl/rise_edge_detect.sv
// ---------------------------------------------------------------------------
// rise_edge_detect
// Rising-edge pulse generator built on a registered history bit.
// The history register resets to RST_VAL; with RST_VAL = 1 an input that is
// already high when reset releases is not mistaken for an edge.
// Ports:
//   clk  in  : clock
//   rst  in  : synchronous, active-high reset
//   sig  in  : level to watch (synchronous to clk)
//   rise out : high for the cycle in which sig is 1 and was 0 last cycle
// ---------------------------------------------------------------------------
module rise_edge_detect #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic src_d;
   logic src_q;

   always_comb begin
      src_d = sig;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_q <= RST_VAL;
      end else begin
         src_q <= src_d;
      end
   end

   assign rise = sig & ~src_q;

endmodule : rise_edge_detect

// File: rtl/sample_capture_stage.sv
// ---------------------------------------------------------------------------
// sample_capture_stage
// Captures one ADC word per rising edge of the divided 48 kHz sample clock
// and hands it to the FIR over valid/ready. A single holding register is
// used; if a new edge arrives before the FIR took the previous word, the
// newer word replaces it (freshest sample wins) and the overrun is counted.
// A watchdog flags the sample clock as lost after TIMEOUT_CYCLES edge-free
// cycles.
//
// Holding register states:
//   state | meaning
//   EMPTY | sample_valid = 0, nothing pending for the FIR
//   FULL  | sample_valid = 1, sample_data holds an unconsumed word
//
// Ports:
//   clk_audio_12M288  in  : 12.288 MHz audio clock (only clock)
//   rst               in  : synchronous, active-high reset
//   sample_rate_clock in  : 48 kHz square wave, synchronous to the clock
//   adc_data          in  : ADC word, taken in the edge cycle
//   sample_data       out : captured sample
//   sample_valid      out : sample_data is unconsumed
//   sample_ready      in  : FIR accepts (transfer = valid && ready)
//   sample_count      out : samples captured since reset (wraps)
//   overrun_count     out : overwritten unconsumed samples (saturates)
//   overrun_flag      out : sticky overrun indicator
//   clock_lost        out : no rising edge for TIMEOUT_CYCLES cycles
// ---------------------------------------------------------------------------
module sample_capture_stage
   import fir_audio_pkg::*;
#(
   parameter int DATA_W         = SAMPLE_W,
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 2 * DIV_RATIO,
   parameter int WD_W           = 10            // 2**WD_W must exceed TIMEOUT_CYCLES
) (
   input  logic              clk_audio_12M288,
   input  logic              rst,
   input  logic              sample_rate_clock,
   input  logic [DATA_W-1:0] adc_data,
   output logic [DATA_W-1:0] sample_data,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic [CNT_W-1:0]  sample_count,
   output logic [CNT_W-1:0]  overrun_count,
   output logic              overrun_flag,
   output logic              clock_lost
);

   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic              rise;
   logic              transfer;
   logic              overrun;

   logic [DATA_W-1:0] sample_data_d,   sample_data_q;
   logic              sample_valid_d,  sample_valid_q;
   logic [CNT_W-1:0]  sample_count_d,  sample_count_q;
   logic [CNT_W-1:0]  overrun_count_d, overrun_count_q;
   logic              overrun_flag_d,  overrun_flag_q;
   logic              clock_lost_d,    clock_lost_q;
   logic [WD_W-1:0]   wd_cnt_d,        wd_cnt_q;

   rise_edge_detect #(
      .RST_VAL (1'b1)
   ) u_rise (
      .clk  (clk_audio_12M288),
      .rst  (rst),
      .sig  (sample_rate_clock),
      .rise (rise)
   );

   always_comb begin
      transfer = sample_valid_q & sample_ready;
      // A rise coinciding with a transfer is not an overrun: the old word
      // leaves in the same cycle the new one arrives.
      overrun  = rise & sample_valid_q & ~sample_ready;

      sample_data_d  = sample_data_q;
      sample_valid_d = sample_valid_q;
      if (rise) begin
         sample_data_d  = adc_data;
         sample_valid_d = 1'b1;
      end else if (transfer) begin
         sample_valid_d = 1'b0;
      end

      sample_count_d = sample_count_q;
      if (rise) begin
         sample_count_d = sample_count_q + CNT_W'(1);
      end

      overrun_count_d = overrun_count_q;
      if (overrun && (overrun_count_q != CNT_MAX)) begin
         overrun_count_d = overrun_count_q + CNT_W'(1);
      end

      overrun_flag_d = overrun_flag_q | overrun;

      wd_cnt_d = wd_cnt_q;
      if (rise) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q != WD_LIMIT) begin
         wd_cnt_d = wd_cnt_q + WD_W'(1);
      end

      // Lost is flagged in the same cycle the counter lands on the limit and
      // drops the cycle after a rise, since the rise clears the counter.
      clock_lost_d = (wd_cnt_d == WD_LIMIT);
   end

   always_ff @(posedge clk_audio_12M288) begin
      if (rst) begin
         sample_data_q   <= '0;
         sample_valid_q  <= 1'b0;
         sample_count_q  <= '0;
         overrun_count_q <= '0;
         overrun_flag_q  <= 1'b0;
         clock_lost_q    <= 1'b0;
         wd_cnt_q        <= '0;
      end else begin
         sample_data_q   <= sample_data_d;
         sample_valid_q  <= sample_valid_d;
         sample_count_q  <= sample_count_d;
         overrun_count_q <= overrun_count_d;
         overrun_flag_q  <= overrun_flag_d;
         clock_lost_q    <= clock_lost_d;
         wd_cnt_q        <= wd_cnt_d;
      end
   end

   assign sample_data   = sample_data_q;
   assign sample_valid  = sample_valid_q;
   assign sample_count  = sample_count_q;
   assign overrun_count = overrun_count_q;
   assign overrun_flag  = overrun_flag_q;
   assign clock_lost    = clock_lost_q;

endmodule : sample_capture_stage

// File: tb/tb_sample_capture_stage.sv
// ---------------------------------------------------------------------------
// tb_sample_capture_stage
// Directed stimulus for sample_capture_stage. Words expected to reach the
// FIR are queued when their edge is driven; a separate monitor pops and
// compares on every valid && ready transfer. Status outputs are checked
// against hand-computed values at chosen points.
// ---------------------------------------------------------------------------
module tb_sample_capture_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        src = 1'b0;
   logic        ready = 1'b0;
   logic [15:0] adc = '0;

   logic [15:0] sample_data;
   logic        sample_valid;
   logic [15:0] sample_count;
   logic [15:0] overrun_count;
   logic        overrun_flag;
   logic        clock_lost;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];

   sample_capture_stage dut (
      .clk_audio_12M288  (clk),
      .rst               (rst),
      .sample_rate_clock (src),
      .adc_data          (adc),
      .sample_data       (sample_data),
      .sample_valid      (sample_valid),
      .sample_ready      (ready),
      .sample_count      (sample_count),
      .overrun_count     (overrun_count),
      .overrun_flag      (overrun_flag),
      .clock_lost        (clock_lost)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL sim_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Raise the sample clock with a new ADC word and step past the capture edge.
   task automatic rise_now(input logic [15:0] val);
      src = 1'b1;
      adc = val;
      tick(1);
   endtask

   // Transfer monitor: inputs only change just after posedge, so what is
   // seen on the falling edge is what the next posedge will act on.
   initial begin : monitor
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (sample_valid === 1'b1 && ready === 1'b1 && rst === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL xfer_unexpected actual=%0h required=none", sample_data);
            end else begin
               e = exp_q.pop_front();
               if (sample_data !== e) begin
                  errors++;
                  $display("FAIL xfer_data actual=%0h required=%0h", sample_data, e);
               end
            end
         end
      end
   end

   initial begin : stim
      // ---- reset state and nominal 128/128 sample clock ----
      rst = 1'b1; src = 1'b0; ready = 1'b1; adc = 16'h1234;
      tick(3);
      chk("rst_valid",   sample_valid,  0);
      chk("rst_data",    sample_data,   0);
      chk("rst_count",   sample_count,  0);
      chk("rst_ovr",     overrun_count, 0);
      chk("rst_flag",    overrun_flag,  0);
      chk("rst_lost",    clock_lost,    0);
      rst = 1'b0;
      tick(2);
      for (int i = 1; i <= 10; i++) begin
         src = 1'b1;
         exp_q.push_back(16'h1234);
         tick(1);
         chk("nom_valid_hi", sample_valid, 1);
         chk("nom_count",    sample_count, i);
         tick(1);
         chk("nom_valid_lo", sample_valid, 0);
         tick(126);
         src = 1'b0;
         tick(128);
      end
      chk("nom_count10", sample_count,  10);
      chk("nom_ovr0",    overrun_count, 0);

      // ---- sample clock high through reset release ----
      rst = 1'b1; src = 1'b1;
      tick(2);
      chk("hold_rst_count", sample_count, 0);
      rst = 1'b0;
      tick(20);
      chk("hold_count",  sample_count, 0);
      chk("hold_valid",  sample_valid, 0);
      src = 1'b0;
      tick(10);
      chk("hold_low_count", sample_count, 0);
      exp_q.push_back(16'h0BEE);
      rise_now(16'h0BEE);
      chk("hold_first_count", sample_count, 1);
      chk("hold_first_valid", sample_valid, 1);
      tick(1);
      chk("hold_first_taken", sample_valid, 0);

      // ---- overrun: three edges without ready ----
      ready = 1'b0;
      for (int v = 1; v <= 3; v++) begin
         src = 1'b0;
         tick(4);
         rise_now(16'(v));
         tick(3);
      end
      chk("ovr_data",  sample_data,   16'h0003);
      chk("ovr_valid", sample_valid,  1);
      chk("ovr_count", overrun_count, 2);
      chk("ovr_flag",  overrun_flag,  1);
      exp_q.push_back(16'h0003);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      chk("ovr_drained", sample_valid, 0);

      // ---- ready exactly on the edge cycle with a word pending ----
      src = 1'b0;
      tick(4);
      rise_now(16'hAAAA);
      tick(2);
      chk("sim_old_data",  sample_data,  16'hAAAA);
      chk("sim_old_valid", sample_valid, 1);
      exp_q.push_back(16'hAAAA);
      src = 1'b0;
      tick(4);
      src = 1'b1; adc = 16'h5555; ready = 1'b1;
      tick(1);
      ready = 1'b0;
      chk("sim_new_data",  sample_data,   16'h5555);
      chk("sim_new_valid", sample_valid,  1);
      chk("sim_ovr_same",  overrun_count, 2);
      exp_q.push_back(16'h5555);
      ready = 1'b1;
      tick(1);
      chk("sim_drained", sample_valid, 0);
      chk("sim_count",   sample_count, 6);

      // ---- watchdog: stop the sample clock low ----
      src = 1'b0;
      tick(4);
      exp_q.push_back(16'h0777);
      rise_now(16'h0777);          // just past edge posedge P
      tick(1);
      src = 1'b0;
      tick(509);                   // P+510
      tick(1);                     // P+511
      chk("wd_not_yet", clock_lost, 0);
      tick(2);                     // P+513
      chk("wd_lost",    clock_lost, 1);
      tick(87);                    // P+600
      chk("wd_lost_hold", clock_lost, 1);
      exp_q.push_back(16'h0888);
      rise_now(16'h0888);
      chk("wd_recovered", clock_lost, 0);
      tick(1);
      chk("wd_drained", sample_valid, 0);
      chk("wd_count",   sample_count, 8);
      chk("wd_flag_sticky", overrun_flag, 1);

      // ---- reset with a pending word and five overruns ----
      ready = 1'b0;
      for (int v = 1; v <= 4; v++) begin
         src = 1'b0;
         tick(4);
         rise_now(16'h00F0 + 16'(v));
         tick(2);
      end
      chk("pre_rst_ovr",   overrun_count, 5);
      chk("pre_rst_count", sample_count,  12);
      chk("pre_rst_valid", sample_valid,  1);
      chk("pre_rst_data",  sample_data,   16'h00F4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("mid_rst_valid", sample_valid,  0);
      chk("mid_rst_data",  sample_data,   0);
      chk("mid_rst_count", sample_count,  0);
      chk("mid_rst_ovr",   overrun_count, 0);
      chk("mid_rst_flag",  overrun_flag,  0);
      chk("mid_rst_lost",  clock_lost,    0);
      ready = 1'b1;
      tick(5);
      chk("post_rst_count", sample_count, 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_sample_capture_stage
